// File: rtl/snake_body_ctrl.sv
// snake_body_ctrl: steps the snake head, keeps the body in a ring buffer,
// detects wall/self collisions and streams draw/erase pixels to the plotter.
module snake_body_ctrl #(
  parameter int         STEP    = 4,
  parameter int         X_LIM   = 160,
  parameter int         Y_LIM   = 120,
  parameter int         START_X = 80,
  parameter int         START_Y = 60,
  parameter int         DEPTH   = 256,
  parameter logic [2:0] COLOUR  = 3'b110
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [3:0]  dirControl,
  input  logic [10:0] grow,
  output logic [7:0]  h_x,
  output logic [6:0]  h_y,
  output logic [7:0]  pix_x,
  output logic [6:0]  pix_y,
  output logic [2:0]  pix_colour,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        busy,
  output logic        dead
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {S_INIT, S_DRAW, S_IDLE, S_MOVE, S_SCAN, S_ERASE, S_DEAD} state_t;
  typedef enum logic [1:0] {D_RIGHT, D_LEFT, D_DOWN, D_UP} dir_t;

  state_t          state, state_nxt;
  dir_t            dir, dir_req;
  logic            dir_ok;
  logic [AW-1:0]   wr_ptr, rd_ptr, scan_addr;
  logic [LW-1:0]   len, scan_left;
  logic            pop, pop_c, commit_pend, cmp_valid, hit, match;
  logic [7:0]      nx_r;
  logic [6:0]      ny_r;
  logic [8:0]      nx_c;
  logic [7:0]      ny_c;
  logic            wall;
  logic [1:0]      k, kn;
  logic            pix_done;
  logic [7:0]      base_x;
  logic [6:0]      base_y;
  logic [2:0]      base_col;
  logic [14:0]     mem [DEPTH];
  logic [14:0]     rd_data, mem_wd;
  logic [AW-1:0]   mem_wa, mem_ra;
  logic            mem_we;

  assign busy     = (state != S_IDLE) && (state != S_DEAD);
  assign dead     = (state == S_DEAD);
  assign kn       = k + 2'd1;
  assign pix_done = pix_valid && pix_ready && (k == 2'd3);
  assign match    = cmp_valid && (rd_data == {nx_r, ny_r});
  assign pop_c    = (11'(len) >= grow) || (len >= LW'(DEPTH - 2));

  // Decode the requested direction; only a single-hot, non-reversing request is taken
  always_comb begin
    dir_req = D_RIGHT;
    if (dirControl[3])      dir_req = D_UP;
    else if (dirControl[2]) dir_req = D_DOWN;
    else if (dirControl[1]) dir_req = D_LEFT;
    dir_ok = $onehot(dirControl) && (dir_req != dir_t'(dir ^ 2'b01));
  end

  // Candidate head one step ahead; the extra MSB acts as the sign for underflow past 0
  always_comb begin
    nx_c = {1'b0, h_x};
    ny_c = {1'b0, h_y};
    case (dir)
      D_RIGHT: nx_c = {1'b0, h_x} + 9'(STEP);
      D_LEFT:  nx_c = {1'b0, h_x} - 9'(STEP);
      D_DOWN:  ny_c = {1'b0, h_y} + 8'(STEP);
      D_UP:    ny_c = {1'b0, h_y} - 8'(STEP);
      default: ;
    endcase
    wall = nx_c[8] || (nx_c[7:0] > 8'(X_LIM - STEP)) ||
           ny_c[7] || (ny_c[6:0] > 7'(Y_LIM - STEP));
  end

  // Pixel source: new head while drawing, the tail cell read from the buffer while erasing
  always_comb begin
    base_x   = nx_r;
    base_y   = ny_r;
    base_col = COLOUR;
    if (state == S_ERASE) begin
      base_x   = rd_data[14:7];
      base_y   = rd_data[6:0];
      base_col = 3'b000;
    end
  end

  // Buffer ports: INIT seeds slot 0, DRAW appends the head; reads follow the scan or the tail
  always_comb begin
    mem_we = 1'b0;
    mem_wa = wr_ptr;
    mem_wd = {nx_r, ny_r};
    mem_ra = rd_ptr;
    if (state == S_INIT) begin
      mem_we = 1'b1;
      mem_wa = '0;
      mem_wd = {8'(START_X), 7'(START_Y)};
    end else if (state == S_DRAW && commit_pend) begin
      mem_we = 1'b1;
    end
    if (state == S_SCAN) mem_ra = scan_addr;
  end

  // Body storage with a registered read port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
    rd_data <= mem[mem_ra];
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_INIT;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  state_nxt = S_DRAW;
      S_DRAW:  if (pix_done) state_nxt = pop ? S_ERASE : S_IDLE;
      S_IDLE:  if (tick) state_nxt = S_MOVE;
      S_MOVE:  state_nxt = wall ? S_DEAD : S_SCAN;
      S_SCAN:  if (scan_left == '0) state_nxt = (hit || match) ? S_DEAD : S_DRAW;
      S_ERASE: if (pix_done) state_nxt = S_IDLE;
      S_DEAD:  state_nxt = S_DEAD;
      default: state_nxt = S_INIT;
    endcase
  end

  // Datapath: direction latch, move/scan bookkeeping, head commit and pixel handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_x         <= 8'(START_X);
      h_y         <= 7'(START_Y);
      dir         <= D_RIGHT;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      len         <= LW'(1);
      nx_r        <= 8'(START_X);
      ny_r        <= 7'(START_Y);
      pop         <= 1'b0;
      commit_pend <= 1'b0;
      scan_addr   <= '0;
      scan_left   <= '0;
      cmp_valid   <= 1'b0;
      hit         <= 1'b0;
      k           <= 2'd0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_colour  <= '0;
      pix_valid   <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          wr_ptr      <= AW'(1);
          len         <= LW'(1);
          nx_r        <= 8'(START_X);
          ny_r        <= 7'(START_Y);
          pop         <= 1'b0;
          commit_pend <= 1'b0;
        end
        S_IDLE: if (tick && dir_ok) dir <= dir_req;
        S_MOVE: begin
          nx_r        <= nx_c[7:0];
          ny_r        <= ny_c[6:0];
          pop         <= pop_c;
          scan_addr   <= rd_ptr + AW'(pop_c);
          scan_left   <= len - LW'(pop_c);
          cmp_valid   <= 1'b0;
          hit         <= 1'b0;
          commit_pend <= 1'b1;
        end
        S_SCAN: begin
          if (match) hit <= 1'b1;
          if (scan_left != '0) begin
            scan_addr <= scan_addr + AW'(1);
            scan_left <= scan_left - LW'(1);
            cmp_valid <= 1'b1;
          end else begin
            cmp_valid <= 1'b0;
          end
        end
        default: ;
      endcase

      if (state == S_DRAW && commit_pend) begin
        h_x         <= nx_r;
        h_y         <= ny_r;
        wr_ptr      <= wr_ptr + AW'(1);
        len         <= len + LW'(1);
        commit_pend <= 1'b0;
      end

      if (state == S_DRAW || state == S_ERASE) begin
        if (!pix_valid) begin
          pix_x      <= base_x;
          pix_y      <= base_y;
          pix_colour <= base_col;
          pix_valid  <= 1'b1;
          k          <= 2'd0;
        end else if (pix_ready) begin
          if (k == 2'd3) begin
            pix_valid <= 1'b0;
            k         <= 2'd0;
            if (state == S_ERASE) begin
              rd_ptr <= rd_ptr + AW'(1);
              len    <= len - LW'(1);
            end
          end else begin
            k     <= kn;
            pix_x <= base_x + {7'd0, kn[0]};
            pix_y <= base_y + {6'd0, kn[1]};
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_snake_body_ctrl.sv
// tb_snake_body_ctrl: table-driven moves plus hand sequences for wall death,
// plotter back-pressure and dropped ticks; pixels are checked against a queue.
module tb_snake_body_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic [3:0]  dirControl = 4'b0000;
  logic [10:0] grow = 11'd0;
  logic        pix_ready = 1'b1;
  logic [7:0]  h_x, pix_x;
  logic [6:0]  h_y, pix_y;
  logic [2:0]  pix_colour;
  logic        pix_valid, busy, dead;

  snake_body_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .dirControl(dirControl), .grow(grow),
    .h_x(h_x), .h_y(h_y), .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .busy(busy), .dead(dead)
  );

  // Free-running clock
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  typedef struct packed {
    logic        rstFirst;
    logic [3:0]  dirc;
    logic [10:0] grw;
    logic [7:0]  hx;
    logic [6:0]  hy;
    logic        erase;
    logic [7:0]  ex;
    logic [6:0]  ey;
    logic        dies;
  } vec_t;

  pix_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  logic prevStall = 1'b0;
  pix_t prevPix;
  vec_t vecs[18];

  // Scoreboard: every accepted pixel must match the next expected one; stalled outputs must hold
  always @(negedge clk) begin
    pix_t got;
    pix_t e;
    got = '{x: pix_x, y: pix_y, c: pix_colour};
    if (rst && prevStall) begin
      total++;
      if ({pix_valid, got} !== {1'b1, prevPix}) begin
        bad++;
        $display("[TB] FAIL stall_hold got v=%b (%0d,%0d,%b) expected (%0d,%0d,%b)",
                 pix_valid, got.x, got.y, got.c, prevPix.x, prevPix.y, prevPix.c);
      end
    end
    if (rst && pix_valid && pix_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL pixel_unexpected got (%0d,%0d,%b) expected none", got.x, got.y, got.c);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          bad++;
          $display("[TB] FAIL pixel got (%0d,%0d,%b) expected (%0d,%0d,%b)",
                   got.x, got.y, got.c, e.x, e.y, e.c);
        end
      end
    end
    prevStall = rst && pix_valid && !pix_ready;
    prevPix   = got;
  end

  task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("[TB] FAIL %s got=%0d expected=%0d", name, got, expv);
    end
  endtask

  task automatic pushCell(input int x, input int y, input logic [2:0] c);
    pix_t p;
    for (int j = 0; j < 4; j++) begin
      p.x = 8'(x + (j % 2));
      p.y = 7'(y + (j / 2));
      p.c = c;
      exp_q.push_back(p);
    end
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (busy && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout busy=1 expected busy=0", name);
    end
  endtask

  task automatic pulseTick(input logic [3:0] d);
    @(posedge clk); #1;
    dirControl = d;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rst = 1'b0;
    tick = 1'b0;
    pix_ready = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_hx", 16'(h_x), 16'd80);
    checkOutput("rst_hy", 16'(h_y), 16'd60);
    checkOutput("rst_valid", 16'(pix_valid), 16'd0);
    checkOutput("rst_pixx", 16'(pix_x), 16'd0);
    checkOutput("rst_busy", 16'(busy), 16'd1);
    checkOutput("rst_dead", 16'(dead), 16'd0);
    pushCell(80, 60, 3'b110);
    rst = 1'b1;
    waitIdle("init");
    checkOutput("init_hx", 16'(h_x), 16'd80);
    checkOutput("init_hy", 16'(h_y), 16'd60);
    checkOutput("init_pixels_left", 16'(exp_q.size()), 16'd0);
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.rstFirst) doReset();
    grow = v.grw;
    if (!v.dies) begin
      pushCell(int'(v.hx), int'(v.hy), 3'b110);
      if (v.erase) pushCell(int'(v.ex), int'(v.ey), 3'b000);
    end
    pulseTick(v.dirc);
    waitIdle("move");
  endtask

  // Main sequence
  initial begin
    int n;
    //          rst  dir      grow    hx     hy     er   ex     ey     dies
    vecs[0]  = '{1'b1, 4'b0001, 11'd6,  8'd84,  7'd60, 1'b0, 8'd0,  7'd0,  1'b0};
    vecs[1]  = '{1'b0, 4'b0001, 11'd6,  8'd88,  7'd60, 1'b0, 8'd0,  7'd0,  1'b0};
    vecs[2]  = '{1'b0, 4'b0001, 11'd6,  8'd92,  7'd60, 1'b0, 8'd0,  7'd0,  1'b0};
    vecs[3]  = '{1'b0, 4'b0001, 11'd6,  8'd96,  7'd60, 1'b0, 8'd0,  7'd0,  1'b0};
    vecs[4]  = '{1'b0, 4'b0001, 11'd6,  8'd100, 7'd60, 1'b0, 8'd0,  7'd0,  1'b0};
    vecs[5]  = '{1'b0, 4'b0001, 11'd6,  8'd104, 7'd60, 1'b1, 8'd80, 7'd60, 1'b0};
    vecs[6]  = '{1'b0, 4'b0010, 11'd6,  8'd108, 7'd60, 1'b1, 8'd84, 7'd60, 1'b0};
    vecs[7]  = '{1'b0, 4'b1000, 11'd6,  8'd108, 7'd56, 1'b1, 8'd88, 7'd60, 1'b0};
    vecs[8]  = '{1'b0, 4'b1100, 11'd6,  8'd108, 7'd52, 1'b1, 8'd92, 7'd60, 1'b0};
    vecs[9]  = '{1'b1, 4'b0001, 11'd10, 8'd84,  7'd60, 1'b0, 8'd0,  7'd0,  1'b0};
    vecs[10] = '{1'b0, 4'b0100, 11'd10, 8'd84,  7'd64, 1'b0, 8'd0,  7'd0,  1'b0};
    vecs[11] = '{1'b0, 4'b0010, 11'd10, 8'd80,  7'd64, 1'b0, 8'd0,  7'd0,  1'b0};
    vecs[12] = '{1'b0, 4'b1000, 11'd10, 8'd80,  7'd64, 1'b0, 8'd0,  7'd0,  1'b1};
    vecs[13] = '{1'b1, 4'b0001, 11'd4,  8'd84,  7'd60, 1'b0, 8'd0,  7'd0,  1'b0};
    vecs[14] = '{1'b0, 4'b0100, 11'd4,  8'd84,  7'd64, 1'b0, 8'd0,  7'd0,  1'b0};
    vecs[15] = '{1'b0, 4'b0010, 11'd4,  8'd80,  7'd64, 1'b0, 8'd0,  7'd0,  1'b0};
    vecs[16] = '{1'b0, 4'b1000, 11'd4,  8'd80,  7'd60, 1'b1, 8'd80, 7'd60, 1'b0};
    vecs[17] = '{1'b0, 4'b1000, 11'd4,  8'd80,  7'd56, 1'b1, 8'd84, 7'd60, 1'b0};

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d_hx", i), 16'(h_x), 16'(vecs[i].hx));
      checkOutput($sformatf("v%0d_hy", i), 16'(h_y), 16'(vecs[i].hy));
      checkOutput($sformatf("v%0d_dead", i), 16'(dead), 16'(vecs[i].dies));
      checkOutput($sformatf("v%0d_pixels_left", i), 16'(exp_q.size()), 16'd0);
    end

    // Walk right to the last legal column, then into the wall
    doReset();
    grow = 11'd1;
    for (int i = 1; i <= 19; i++) begin
      pushCell(80 + 4 * i, 60, 3'b110);
      pushCell(80 + 4 * (i - 1), 60, 3'b000);
      pulseTick(4'b0001);
      waitIdle("walk");
    end
    checkOutput("walk_hx", 16'(h_x), 16'd156);
    checkOutput("walk_pixels_left", 16'(exp_q.size()), 16'd0);
    pulseTick(4'b0001);
    waitIdle("wall");
    checkOutput("wall_dead", 16'(dead), 16'd1);
    checkOutput("wall_hx", 16'(h_x), 16'd156);
    checkOutput("wall_busy", 16'(busy), 16'd0);
    pulseTick(4'b1000);
    pulseTick(4'b1000);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("dead_hx", 16'(h_x), 16'd156);
    checkOutput("dead_hy", 16'(h_y), 16'd60);
    checkOutput("dead_sticky", 16'(dead), 16'd1);
    checkOutput("dead_busy", 16'(busy), 16'd0);

    // Plotter stalls mid-draw while a tick arrives during the stream
    doReset();
    grow = 11'd10;
    pushCell(84, 60, 3'b110);
    pulseTick(4'b0001);
    n = 0;
    while (!pix_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("stall_valid_seen", 16'(pix_valid), 16'd1);
    @(posedge clk); #1;
    pix_ready = 1'b0;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    pix_ready = 1'b1;
    waitIdle("stall");
    repeat (6) @(posedge clk);
    #1;
    checkOutput("stall_hx", 16'(h_x), 16'd84);
    checkOutput("stall_hy", 16'(h_y), 16'd60);
    checkOutput("stall_busy", 16'(busy), 16'd0);
    checkOutput("stall_pixels_left", 16'(exp_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the sequence never completes
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog sim_time expired expected finish");
    $fatal(1, "[TB] watchdog");
  end
endmodule
